// File: rtl/csr_ram_arb_pkg.sv
// Shared types and width helpers for the CSR-to-RAM port arbiter.
package csr_ram_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // Width of an index able to address n requesters (at least 1 bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of a counter that counts 0 .. t-1 (at least 1 bit).
  function automatic int unsigned tmo_cnt_width(input int unsigned t);
    return (t <= 2) ? 1 : $clog2(t);
  endfunction

endpackage

// File: rtl/csr_ram_port_arbiter_rr_prio_picker.sv
// Round-robin priority picker: first set request at or above ptr, wrapping.
module rr_prio_picker
  import csr_ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_valid_c,
  output logic [IDX_W-1:0]   o_idx_c
);

  // Scan NUM_REQ positions starting at ptr; the first hit wins.
  always_comb begin
    logic [IDX_W-1:0] w_pos;
    o_valid_c = 1'b0;
    o_idx_c   = '0;
    w_pos     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_pos = IDX_W'((32'(i_ptr) + k) % NUM_REQ);
      if (!o_valid_c && i_req[w_pos]) begin
        o_valid_c = 1'b1;
        o_idx_c   = w_pos;
      end
    end
  end

endmodule

// File: rtl/csr_ram_port_arbiter.sv
// Round-robin arbiter sharing one CSR-to-RAM bridge port between NUM_REQ
// requesters, one access outstanding at a time.
// Optional feature: define CSR_RAM_ARB_TIMEOUT_EN to bound the WAIT state
// to TIMEOUT_CYCLES and add the o_timeout flag.
module csr_ram_port_arbiter
  import csr_ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ             = 2,
  parameter int unsigned WORD_BIT_WIDTH      = 32,
  parameter int unsigned BYTE_ADDR_BIT_WIDTH = 8,
  parameter int unsigned TIMEOUT_CYCLES      = 64
) (
  input  logic                                              i_clk,
  input  logic                                              i_async_rst,
  input  logic [NUM_REQ-1:0]                                i_req,
  input  logic [NUM_REQ-1:0]                                i_req_is_wr,
  input  logic [NUM_REQ-1:0][BYTE_ADDR_BIT_WIDTH-1:0]       i_byte_addr,
  input  logic [NUM_REQ-1:0][WORD_BIT_WIDTH-1:0]            i_wr_data,
  input  logic [NUM_REQ-1:0][WORD_BIT_WIDTH-1:0]            i_wr_bit_en,
  output logic [NUM_REQ-1:0]                                o_rd_ack,
  output logic [NUM_REQ-1:0]                                o_wr_ack,
  output logic [WORD_BIT_WIDTH-1:0]                         o_rd_data,
  output logic                                              o_acc_req,
  output logic                                              o_acc_req_is_wr,
  output logic [BYTE_ADDR_BIT_WIDTH-1:0]                    o_byte_addr,
  output logic [WORD_BIT_WIDTH-1:0]                         o_wr_data,
  output logic [WORD_BIT_WIDTH-1:0]                         o_wr_bit_en,
  input  logic                                              i_rd_ack,
  input  logic [WORD_BIT_WIDTH-1:0]                         i_rd_data,
  input  logic                                              i_wr_ack
`ifdef CSR_RAM_ARB_TIMEOUT_EN
  ,
  output logic                                              o_timeout
`endif
);

  localparam int unsigned IW = idx_width(NUM_REQ);

  // Elaboration-time parameter sanity checks.
  if (NUM_REQ < 2) begin : g_chk_num_req
    $error("NUM_REQ must be >= 2");
  end
  if ((WORD_BIT_WIDTH < 8) || ((WORD_BIT_WIDTH & (WORD_BIT_WIDTH - 1)) != 0)) begin : g_chk_word
    $error("WORD_BIT_WIDTH must be a power of 2 and >= 8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_chk_tmo
    $error("TIMEOUT_CYCLES must be >= 2");
  end

  arb_state_e                     r_state;
  arb_state_e                     w_state_nxt;
  logic [IW-1:0]                  r_ptr;
  logic [IW-1:0]                  r_grant;
  logic                           r_is_wr;
  logic [BYTE_ADDR_BIT_WIDTH-1:0] r_addr;
  logic [WORD_BIT_WIDTH-1:0]      r_wr_data;
  logic [WORD_BIT_WIDTH-1:0]      r_wr_bit_en;
  logic                           r_acc_req;
  logic [NUM_REQ-1:0]             r_rd_ack;
  logic [NUM_REQ-1:0]             r_wr_ack;
  logic [WORD_BIT_WIDTH-1:0]      r_rd_data;

  logic                           w_pick_valid;
  logic [IW-1:0]                  w_pick_idx;
  logic                           w_ack_match;
  logic                           w_tmo_hit;
  logic                           w_load_cmd;
  logic                           w_finish;
  logic                           w_acc_req_nxt;
  logic [NUM_REQ-1:0]             w_rd_ack_nxt;
  logic [NUM_REQ-1:0]             w_wr_ack_nxt;
  logic [IW-1:0]                  w_ptr_inc;

  rr_prio_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IW)
  ) u_picker (
    .i_req     (i_req),
    .i_ptr     (r_ptr),
    .o_valid_c (w_pick_valid),
    .o_idx_c   (w_pick_idx)
  );

  // Only the ack type matching the latched command can finish an access.
  assign w_ack_match = r_is_wr ? i_wr_ack : i_rd_ack;
  assign w_ptr_inc   = (r_grant == IW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;

`ifdef CSR_RAM_ARB_TIMEOUT_EN
  localparam int unsigned TCW = tmo_cnt_width(TIMEOUT_CYCLES);

  logic [TCW-1:0] r_tmo_cnt;
  logic           r_timeout;
  logic           w_timeout_nxt;

  assign w_tmo_hit     = (r_state == WAIT) && (r_tmo_cnt == TCW'(TIMEOUT_CYCLES - 1));
  assign w_timeout_nxt = w_finish && !w_ack_match;
  assign o_timeout     = r_timeout;

  // WAIT-cycle counter and registered timeout flag.
  always_ff @(posedge i_clk or posedge i_async_rst) begin
    if (i_async_rst) begin
      r_tmo_cnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_tmo_cnt <= (r_state == WAIT) ? r_tmo_cnt + 1'b1 : '0;
      r_timeout <= w_timeout_nxt;
    end
  end
`else
  assign w_tmo_hit = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_async_rst) begin
    if (i_async_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and next values of the registered outputs.
  always_comb begin
    w_state_nxt   = r_state;
    w_load_cmd    = 1'b0;
    w_finish      = 1'b0;
    w_acc_req_nxt = 1'b0;
    w_rd_ack_nxt  = '0;
    w_wr_ack_nxt  = '0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_load_cmd    = 1'b1;
          w_acc_req_nxt = 1'b1;
          w_state_nxt   = ISSUE;
        end
      end
      ISSUE: begin
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (w_ack_match || w_tmo_hit) begin
          w_finish    = 1'b1;
          w_state_nxt = RESP;
          if (r_is_wr) begin
            w_wr_ack_nxt[r_grant] = 1'b1;
          end else begin
            w_rd_ack_nxt[r_grant] = 1'b1;
          end
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Command latch, rr pointer, read-data latch and registered pulses.
  always_ff @(posedge i_clk or posedge i_async_rst) begin
    if (i_async_rst) begin
      r_ptr       <= '0;
      r_grant     <= '0;
      r_is_wr     <= 1'b0;
      r_addr      <= '0;
      r_wr_data   <= '0;
      r_wr_bit_en <= '0;
      r_acc_req   <= 1'b0;
      r_rd_ack    <= '0;
      r_wr_ack    <= '0;
      r_rd_data   <= '0;
    end else begin
      r_acc_req <= w_acc_req_nxt;
      r_rd_ack  <= w_rd_ack_nxt;
      r_wr_ack  <= w_wr_ack_nxt;
      if (w_load_cmd) begin
        r_grant     <= w_pick_idx;
        r_is_wr     <= i_req_is_wr[w_pick_idx];
        r_addr      <= i_byte_addr[w_pick_idx];
        r_wr_data   <= i_wr_data[w_pick_idx];
        r_wr_bit_en <= i_wr_bit_en[w_pick_idx];
      end
      if (w_finish) begin
        r_ptr <= w_ptr_inc;
        if (!w_ack_match) begin
          r_rd_data <= '0;
        end else if (!r_is_wr) begin
          r_rd_data <= i_rd_data;
        end
      end
    end
  end

  assign o_acc_req       = r_acc_req;
  assign o_acc_req_is_wr = r_is_wr;
  assign o_byte_addr     = r_addr;
  assign o_wr_data       = r_wr_data;
  assign o_wr_bit_en     = r_wr_bit_en;
  assign o_rd_ack        = r_rd_ack;
  assign o_wr_ack        = r_wr_ack;
  assign o_rd_data       = r_rd_data;

endmodule

// File: tb/tb_csr_ram_port_arbiter.sv
// Directed bench for csr_ram_port_arbiter with NUM_REQ=3, TIMEOUT_CYCLES=4.
module tb_csr_ram_port_arbiter;

  localparam int unsigned NR = 3;
  localparam int unsigned W  = 32;
  localparam int unsigned AW = 8;

  logic                   i_clk = 1'b0;
  logic                   i_async_rst;
  logic [NR-1:0]          i_req;
  logic [NR-1:0]          i_req_is_wr;
  logic [NR-1:0][AW-1:0]  i_byte_addr;
  logic [NR-1:0][W-1:0]   i_wr_data;
  logic [NR-1:0][W-1:0]   i_wr_bit_en;
  logic [NR-1:0]          o_rd_ack;
  logic [NR-1:0]          o_wr_ack;
  logic [W-1:0]           o_rd_data;
  logic                   o_acc_req;
  logic                   o_acc_req_is_wr;
  logic [AW-1:0]          o_byte_addr;
  logic [W-1:0]           o_wr_data;
  logic [W-1:0]           o_wr_bit_en;
  logic                   i_rd_ack;
  logic [W-1:0]           i_rd_data;
  logic                   i_wr_ack;
`ifdef CSR_RAM_ARB_TIMEOUT_EN
  logic                   o_timeout;
`endif

  csr_ram_port_arbiter #(
    .NUM_REQ             (NR),
    .WORD_BIT_WIDTH      (W),
    .BYTE_ADDR_BIT_WIDTH (AW),
    .TIMEOUT_CYCLES      (4)
  ) dut (
    .i_clk           (i_clk),
    .i_async_rst     (i_async_rst),
    .i_req           (i_req),
    .i_req_is_wr     (i_req_is_wr),
    .i_byte_addr     (i_byte_addr),
    .i_wr_data       (i_wr_data),
    .i_wr_bit_en     (i_wr_bit_en),
    .o_rd_ack        (o_rd_ack),
    .o_wr_ack        (o_wr_ack),
    .o_rd_data       (o_rd_data),
    .o_acc_req       (o_acc_req),
    .o_acc_req_is_wr (o_acc_req_is_wr),
    .o_byte_addr     (o_byte_addr),
    .o_wr_data       (o_wr_data),
    .o_wr_bit_en     (o_wr_bit_en),
    .i_rd_ack        (i_rd_ack),
    .i_rd_data       (i_rd_data),
    .i_wr_ack        (i_wr_ack)
`ifdef CSR_RAM_ARB_TIMEOUT_EN
    ,
    .o_timeout       (o_timeout)
`endif
  );

  always #5 i_clk = ~i_clk;

  // One single-requester access: lat = cycle the bridge acks, stray = cycle a
  // wrong-type ack is injected (-1 for none).
  typedef struct {
    int         idx;
    bit         wr;
    logic [7:0] addr;
    logic [31:0] wdata;
    logic [31:0] ben;
    logic [31:0] rdata;
    int         lat;
    int         stray;
  } vec_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_rd  = '0;
  vec_t        vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_req       = '0;
    i_req_is_wr = '0;
    i_byte_addr = '0;
    i_wr_data   = '0;
    i_wr_bit_en = '0;
    i_rd_ack    = 1'b0;
    i_wr_ack    = 1'b0;
    i_rd_data   = '0;
  endtask

  task automatic check_quiet(input string name);
    chk({name, "_acc"}, 64'(o_acc_req), 64'd0);
    chk({name, "_rdack"}, 64'(o_rd_ack), 64'd0);
    chk({name, "_wrack"}, 64'(o_wr_ack), 64'd0);
  endtask

  // Called at the start of an IDLE cycle (cycle 0).
  task automatic do_access(input vec_t v, input int n);
    logic [NR-1:0] exp_ack;
    string tag;
    tag = $sformatf("v%0d", n);
    i_req_is_wr[v.idx] = v.wr;
    i_byte_addr[v.idx] = v.addr;
    i_wr_data[v.idx]   = v.wdata;
    i_wr_bit_en[v.idx] = v.ben;
    i_req[v.idx]       = 1'b1;
    for (int c = 0; c <= v.lat + 2; c++) begin
      chk({tag, "_acc_req"}, 64'(o_acc_req), 64'(c == 1));
      if (c == 1) begin
        chk({tag, "_acc_is_wr"}, 64'(o_acc_req_is_wr), 64'(v.wr));
        chk({tag, "_acc_addr"}, 64'(o_byte_addr), 64'(v.addr));
        chk({tag, "_acc_wdata"}, 64'(o_wr_data), 64'(v.wdata));
        chk({tag, "_acc_ben"}, 64'(o_wr_bit_en), 64'(v.ben));
      end
      exp_ack = (c == v.lat + 1) ? NR'(1 << v.idx) : '0;
      chk({tag, "_wr_ack"}, 64'(o_wr_ack), v.wr ? 64'(exp_ack) : 64'd0);
      chk({tag, "_rd_ack"}, 64'(o_rd_ack), v.wr ? 64'd0 : 64'(exp_ack));
      if (c == v.lat + 1) begin
        if (!v.wr) last_rd = v.rdata;
        chk({tag, "_rd_data"}, 64'(o_rd_data), 64'(last_rd));
`ifdef CSR_RAM_ARB_TIMEOUT_EN
        chk({tag, "_timeout"}, 64'(o_timeout), 64'd0);
`endif
        i_req[v.idx] = 1'b0;
      end
      i_rd_ack  = (!v.wr && c == v.lat) || (v.wr && c == v.stray);
      i_wr_ack  = (v.wr && c == v.lat) || (!v.wr && c == v.stray);
      i_rd_data = (!v.wr && c == v.lat) ? v.rdata : (32'hBAD0_0000 | 32'(c));
      step();
    end
    i_rd_ack = 1'b0;
    i_wr_ack = 1'b0;
  endtask

  initial begin
    int            grants;
    int            acc_cnt;
    int            k;
    bit            inflight;
    bit            pend;
    logic [NR-1:0] reraise;

    vecs[0] = '{0, 1'b1, 8'h10, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h0,        2, -1};
    vecs[1] = '{1, 1'b0, 8'h20, 32'h0,        32'h0,        32'h12345678, 3, -1};
    vecs[2] = '{2, 1'b1, 8'hFC, 32'hA5A55A5A, 32'h0000FFFF, 32'h0,        2, -1};
    vecs[3] = '{0, 1'b0, 8'h04, 32'h13572468, 32'hF0F0F0F0, 32'hCAFEF00D, 2, -1};
    vecs[4] = '{1, 1'b1, 8'h33, 32'h01020304, 32'hFF00FF00, 32'h0,        4,  2};
    vecs[5] = '{2, 1'b0, 8'h80, 32'h0,        32'h0,        32'h89ABCDEF, 5,  3};
    vecs[6] = '{0, 1'b0, 8'hFF, 32'h0,        32'h0,        32'h0F1E2D3C, 3,  0};

    clear_inputs();
    i_async_rst = 1'b1;
    #3;
    check_quiet("rst");
    chk("rst_rd_data", 64'(o_rd_data), 64'd0);
    chk("rst_addr", 64'(o_byte_addr), 64'd0);
    step();
    step();
    i_async_rst = 1'b0;
    step();

    // Contention: all three requesting continuously, expect 0,1,2,0,1,2,...
    for (int r = 0; r < int'(NR); r++) begin
      i_req_is_wr[r] = 1'b1;
      i_byte_addr[r] = AW'(8'h40 + r);
      i_wr_data[r]   = W'(r);
      i_wr_bit_en[r] = '1;
    end
    i_req    = '1;
    grants   = 0;
    acc_cnt  = 0;
    inflight = 1'b0;
    pend     = 1'b0;
    reraise  = '0;
    for (int cyc = 0; cyc < 300 && grants < 9; cyc++) begin
      step();
      i_req    = i_req | reraise;
      reraise  = '0;
      i_wr_ack = pend;
      pend     = 1'b0;
      if (o_acc_req) begin
        chk("cont_single_inflight", 64'(inflight), 64'd0);
        chk("cont_acc_addr", 64'(o_byte_addr), 64'(8'h40 + (acc_cnt % 3)));
        inflight = 1'b1;
        acc_cnt++;
        pend = 1'b1;
      end
      if (o_wr_ack != '0) begin
        chk("cont_grant_order", 64'(o_wr_ack), 64'(1 << (grants % 3)));
        k = 0;
        for (int b = 0; b < int'(NR); b++) if (o_wr_ack[b]) k = b;
        inflight = 1'b0;
        grants++;
        if (grants == 9) begin
          i_req = '0;
        end else begin
          i_req[k]   = 1'b0;
          reraise[k] = 1'b1;
        end
      end
    end
    i_wr_ack = 1'b0;
    chk("cont_grants", 64'(grants), 64'd9);
    chk("cont_acc_cnt", 64'(acc_cnt), 64'd9);
    step();
    check_quiet("cont_end");
    step();

    // Table-driven single accesses.
    clear_inputs();
    for (int n = 0; n < 7; n++) do_access(vecs[n], n);

    // Stray acks in IDLE with no requester.
    i_rd_ack  = 1'b1;
    i_wr_ack  = 1'b1;
    i_rd_data = 32'h55AA55AA;
    step();
    i_rd_ack = 1'b0;
    i_wr_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_quiet("idle_stray");
      chk("idle_stray_rd_data", 64'(o_rd_data), 64'(last_rd));
      step();
    end

`ifdef CSR_RAM_ARB_TIMEOUT_EN
    // Read that the bridge never acks: timeout RESP four cycles after WAIT.
    i_req_is_wr[1] = 1'b0;
    i_byte_addr[1] = 8'h55;
    i_req[1]       = 1'b1;
    for (int c = 0; c <= 7; c++) begin
      chk("tmo_acc_req", 64'(o_acc_req), 64'(c == 1));
      chk("tmo_rd_ack", 64'(o_rd_ack), (c == 6) ? 64'h2 : 64'd0);
      chk("tmo_wr_ack", 64'(o_wr_ack), 64'd0);
      chk("tmo_flag", 64'(o_timeout), 64'(c == 6));
      if (c == 6) begin
        chk("tmo_rd_data", 64'(o_rd_data), 64'd0);
        i_req[1] = 1'b0;
        last_rd  = '0;
      end
      step();
    end
`endif

    // Reset during WAIT; move ptr off 0 first so its reset is observable.
    do_access('{1, 1'b1, 8'h60, 32'h600D600D, 32'hFFFFFFFF, 32'h0, 2, -1}, 7);
    i_req_is_wr[1] = 1'b1;
    i_byte_addr[1] = 8'h77;
    i_wr_data[1]   = 32'h11;
    i_req[1]       = 1'b1;
    step();
    chk("rstmid_acc_req", 64'(o_acc_req), 64'd1);
    step();
    #2;
    i_async_rst = 1'b1;
    #1;
    check_quiet("rstmid");
    chk("rstmid_addr", 64'(o_byte_addr), 64'd0);
    chk("rstmid_wdata", 64'(o_wr_data), 64'd0);
    chk("rstmid_is_wr", 64'(o_acc_req_is_wr), 64'd0);
    chk("rstmid_rd_data", 64'(o_rd_data), 64'd0);
    i_req = '0;
    step();
    i_async_rst = 1'b0;
    i_wr_ack    = 1'b1;
    step();
    i_wr_ack = 1'b0;
    check_quiet("late_ack");
    step();
    check_quiet("late_ack2");
    i_req_is_wr    = '1;
    i_byte_addr[0] = 8'h30;
    i_byte_addr[2] = 8'h32;
    i_req          = 3'b101;
    step();
    chk("post_rst_acc", 64'(o_acc_req), 64'd1);
    chk("post_rst_addr", 64'(o_byte_addr), 64'h30);
    step();
    i_wr_ack = 1'b1;
    step();
    i_wr_ack = 1'b0;
    chk("post_rst_wr_ack", 64'(o_wr_ack), 64'h1);
    i_req = '0;
    step();
    check_quiet("post_rst_idle");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
